// File: rtl/addsub_iter_pkg.sv
// ============================================================================
// addsub_iter_pkg : shared FSM encoding and default sizing for addsub_iter
// Revision: 1.0
// ============================================================================
`default_nettype none

package addsub_iter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bit_inverter.sv
// ============================================================================
// bit_inverter : bitwise one's complement of a WIDTH-bit vector
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_inverter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = ~data_i;

endmodule

`default_nettype wire

// File: rtl/addsub_iter.sv
// ============================================================================
// addsub_iter : iterative two's-complement adder/subtractor, CHUNK bits/cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module addsub_iter
    import addsub_iter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             ovf_q, ovf_d;
    logic             ne_q, ne_d;
    logic             lt_q, lt_d;
    logic [KW-1:0]    k_q, k_d;

    logic [WIDTH-1:0] w_b_inv;
    logic [WIDTH-1:0] w_b_sel;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_c_msb;
    logic             w_last;

    bit_inverter #(
        .WIDTH (WIDTH)
    ) u_bit_inverter (
        .data_i (data_operandB),
        .data_o (w_b_inv)
    );

    assign w_b_sel   = ctrl_sub ? w_b_inv : data_operandB;

    assign w_a_chunk = a_q[k_q*CHUNK +: CHUNK];
    assign w_b_chunk = b_q[k_q*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk's top bit recovered from its sum bit and operands.
    assign w_c_msb   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    assign w_last    = (k_q == KW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        ovf_d   = ovf_q;
        ne_d    = ne_q;
        lt_d    = lt_q;
        k_d     = k_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = data_operandA;
                    b_d     = w_b_sel;
                    carry_d = ctrl_sub;
                    sub_d   = ctrl_sub;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[k_q*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
                carry_d = w_sum[CHUNK];
                k_d     = k_q + 1'b1;
                if (w_last) begin
                    ovf_d   = w_c_msb ^ w_sum[CHUNK];
                    res_d   = acc_d;
                    ne_d    = sub_q & (|acc_d);
                    lt_d    = sub_q & (acc_d[WIDTH-1] ^ ovf_d);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ne_q    <= 1'b0;
            lt_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            ne_q    <= ne_d;
            lt_q    <= lt_d;
            k_q     <= k_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign data_result = res_q;
    assign overflow    = ovf_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_iter.sv
// ============================================================================
// tb_addsub_iter : directed vectors against an arithmetic reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_addsub_iter;

    localparam int W   = 32;
    localparam int NCH = 4;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         ctrl_sub  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] opA       = '0;
    logic [W-1:0] opB       = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] data_result;
    logic         overflow;
    logic         isNotEqual;
    logic         isLessThan;

    int errors = 0;
    int checks = 0;

    addsub_iter #(
        .WIDTH (W),
        .CHUNK (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (opA),
        .data_operandB (opB),
        .ctrl_sub      (ctrl_sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .overflow      (overflow),
        .isNotEqual    (isNotEqual),
        .isLessThan    (isLessThan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a busy window of NCH cycles after acceptance, then a
    // result held until consumed; values come from plain signed arithmetic.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_ovf  = 1'b0;
    logic         m_ne   = 1'b0;
    logic         m_lt   = 1'b0;
    logic [W-1:0] p_res  = '0;
    logic         p_ovf  = 1'b0;
    logic         p_ne   = 1'b0;
    logic         p_lt   = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
            m_res = '0; m_ovf = 1'b0; m_ne = 1'b0; m_lt = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == NCH) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_res = p_res; m_ovf = p_ovf; m_ne = p_ne; m_lt = p_lt;
            end
        end else if (in_valid) begin
            p_res = ctrl_sub ? (opA - opB) : (opA + opB);
            if (ctrl_sub) p_ovf = (opA[W-1] != opB[W-1]) && (p_res[W-1] != opA[W-1]);
            else          p_ovf = (opA[W-1] == opB[W-1]) && (p_res[W-1] != opA[W-1]);
            p_ne   = ctrl_sub && (opA != opB);
            p_lt   = ctrl_sub && ($signed(opA) < $signed(opB));
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    end

    always @(negedge clock) begin
        chk("cmp_in_ready",   W'(in_ready),   W'(!m_busy && !m_done));
        chk("cmp_out_valid",  W'(out_valid),  W'(m_done));
        chk("cmp_result",     data_result,    m_res);
        chk("cmp_overflow",   W'(overflow),   W'(m_ovf));
        chk("cmp_isNotEqual", W'(isNotEqual), W'(m_ne));
        chk("cmp_isLessThan", W'(isLessThan), W'(m_lt));
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic eo, input logic ene,
                         input logic elt, input int hold);
        int lat;
        chk("ready_before_accept", W'(in_ready), W'(1));
        in_valid = 1'b1; opA = a; opB = b; ctrl_sub = s;
        @(posedge clock); #1;
        in_valid = 1'b0; opA = ~a; opB = a ^ b; ctrl_sub = ~s;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", W'(lat), W'(NCH + 1));
        chk("lit_result",   data_result,    er);
        chk("lit_overflow", W'(overflow),   W'(eo));
        chk("lit_ne",       W'(isNotEqual), W'(ene));
        chk("lit_lt",       W'(isLessThan), W'(elt));
        for (int i = 0; i < hold; i++) begin
            opA = $urandom; opB = $urandom; ctrl_sub = 1'($urandom); in_valid = 1'b1;
            @(posedge clock); #1;
            chk("hold_result",    data_result,   er);
            chk("hold_overflow",  W'(overflow),  W'(eo));
            chk("hold_in_ready",  W'(in_ready),  W'(0));
            chk("hold_out_valid", W'(out_valid), W'(1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("release_in_ready",  W'(in_ready),  W'(1));
        chk("release_out_valid", W'(out_valid), W'(0));
        chk("release_result",    data_result,   er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready",  W'(in_ready),  W'(1));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_result",    data_result,   '0);
        reset = 1'b0;

        do_op(32'd5,          32'd3,          1'b0, 32'd8,          1'b0, 1'b0, 1'b0, 0);
        do_op(32'd3,          32'd5,          1'b1, 32'hFFFF_FFFE,  1'b0, 1'b1, 1'b1, 3);
        do_op(32'h1234_5678,  32'h1234_5678,  1'b1, 32'h0,          1'b0, 1'b0, 1'b0, 0);
        do_op(32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b1, 0);
        do_op(32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b1, 1'b0, 1'b0, 0);

        // Abandon a 5+3 after two chunks; everything must return to zero.
        in_valid = 1'b1; opA = 32'd5; opB = 32'd3; ctrl_sub = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("midrun_in_ready",  W'(in_ready),   W'(1));
        chk("midrun_out_valid", W'(out_valid),  W'(0));
        chk("midrun_result",    data_result,    '0);
        chk("midrun_overflow",  W'(overflow),   W'(0));
        @(posedge clock); #1;
        chk("midrun_next_in_ready", W'(in_ready), W'(1));
        chk("midrun_next_result",   data_result,  '0);
        reset = 1'b0;

        do_op(32'h0000_00FF,  32'd1,          1'b0, 32'h0000_0100,  1'b0, 1'b0, 1'b0, 0);
        do_op(32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 0);
        do_op(32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 32'h0000_0001,  1'b1, 1'b1, 1'b1, 0);

        @(posedge clock); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
